bcd_scan_display: RTL
=====================

// Module: bcd_scan_display
// PURPOSE
//  Parametrised N-digit decimal display driver for multiplexed 7-segment banks.
//  Converts an N_IN-bit binary value to BCD with a sequential double-dabble engine,
//  latches the result, then time-multiplexes the digits onto one shared segment bus.
//  Sits between switch/counter logic and the board display pins. Adds overflow
//  indication and leading-zero blanking.
// PARAMETERS
//  N_IN      14     binary input width (1..32)
//  N_DIGITS  4      number of digits/anodes (1..8)
//  SCAN_DIV  50000  clk cycles per digit slot (>=2)
//  SEG_ALOW  1      1: seg/an active-low (common anode); 0: active-high
// PORTS
//  clk       in   1           system clock, all logic on rising edge
//  rst       in   1           synchronous reset, active-high
//  bin_in    in   N_IN        binary value, sampled only on accepted load
//  load      in   1           conversion request, single-cycle strobe
//  blank_lz  in   1           1: blank leading zeros (sampled live)
//  busy      out  1           conversion in progress
//  done      out  1           1-cycle pulse: new value latched to display
//  overflow  out  1           latched value >= 10**N_DIGITS
//  seg       out  7           segments {g,f,e,d,c,b,a}, registered
//  an        out  N_DIGITS    digit enables, one-hot, registered
// BEHAVIOUR
//  Reset (synchronous): busy=0, done=0, overflow=0, display digits=0, scan index=0,
//   prescaler=0, seg=all off, an=all off. Reset mid-conversion aborts it and clears the shift register.
//  Converter FSM: IDLE -> SHIFT -> LATCH -> IDLE.
//   IDLE: load=1 accepted; captures bin_in into shift reg low bits, BCD part=0,
//    bit counter=N_IN; overflow_nxt = (bin_in >= 10**N_DIGITS); -> SHIFT.
//   SHIFT: each cycle add 3 to every BCD nibble >=5, then shift whole reg left 1;
//    counter decrements; after N_IN shifts -> LATCH.
//   LATCH: copy BCD nibbles to display regs, overflow<=overflow_nxt, done=1 -> IDLE.
//   busy=1 in SHIFT and LATCH. load while busy is ignored (not queued).
//  Latency: load at cycle T -> done high at T+N_IN+2, display regs valid from T+N_IN+3.
//  Shift register width N_IN+4*N_DIGITS; BCD digits above N_DIGITS are discarded.
//  Display content per digit i (0 = least significant):
//   overflow=1         -> dash (all digits)
//   blank_lz=1, i>0, digit i and every higher digit == 0 -> blank
//   else               -> decimal pattern of digit i
//   digit 0 is never blanked (value 0 shows "0").
//  Active-high patterns: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F
//   dash=40 blank=00; SEG_ALOW=1 inverts seg and an at the output register.
//  Scan: prescaler counts 0..SCAN_DIV-1 and wraps; on wrap index advances,
//   N_DIGITS-1 -> 0. seg/an updated every cycle from current index (1-cycle
//   register delay); first cycle after reset release drives digit 0.
//  Display regs update only in LATCH; scanning never stalls during conversion.
//  Load and reset asserted together: reset wins.
// TESTING (SCAN_DIV=4, N_IN=14, N_DIGITS=4, SEG_ALOW=0 unless stated)
//  1 load bin_in=1234 -> busy 15 cycles, done at T+16; scan shows digits 4,3,2,1
//    as seg 66,4F,5B,06 with an 0001,0010,0100,1000, 4 cycles each.
//  2 bin_in=7, blank_lz=1 -> an=0001 seg=07; digits 1..3 seg=00. blank_lz=0 -> 3F.
//    bin_in=0, blank_lz=1 -> digit 0 seg=3F, others 00.
//  3 bin_in=10000 -> overflow=1, all digits seg=40; then bin_in=9999 -> overflow=0, 6F x4.
//  4 load 1234, second load 5678 at T+5 -> ignored, single done, shows 1234.
//  5 rst asserted at T+6 of a conversion -> next cycle busy=0, seg=00, an=0000;
//    afterwards display shows 0; new load 42 converts normally.
//  6 SEG_ALOW=1, bin_in=8 -> digit 0 seg=00 (7F inverted), an=1110.

Source files
------------

// File: rtl/bcd_scan_display.sv
// Binary-to-BCD display driver for a multiplexed 7-segment bank.
// A sequential double-dabble engine converts a loaded value. The result is
// latched into display registers, then scanned one digit per slot.
module bcd_scan_display #(
   parameter int unsigned N_IN     = 14,
   parameter int unsigned N_DIGITS = 4,
   parameter int unsigned SCAN_DIV = 50000,
   parameter bit          SEG_ALOW = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_IN-1:0]     bin_in,
   input  logic                load,
   input  logic                blank_lz,
   output logic                busy,
   output logic                done,
   output logic                overflow,
   output logic [6:0]          seg,
   output logic [N_DIGITS-1:0] an
);

   localparam int unsigned SrW  = N_IN + 4 * N_DIGITS;
   localparam int unsigned CntW = $clog2(N_IN + 1);
   localparam int unsigned IdxW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int unsigned PreW = $clog2(SCAN_DIV);
   localparam logic [63:0] Limit = 64'(10 ** N_DIGITS);

   typedef enum logic [1:0] {StIdle, StShift, StLatch} state_e;

   state_e                    state_q, state_d;
   logic [SrW-1:0]            sr_q, sr_d, sr_adj;
   logic [CntW-1:0]           cnt_q, cnt_d;
   logic                      ovf_nxt_q, ovf_nxt_d;
   logic                      ovf_q, ovf_d;
   logic                      done_q, done_d;
   logic [4*N_DIGITS-1:0]     disp_q, disp_d;
   logic [PreW-1:0]           pre_q, pre_d;
   logic [IdxW-1:0]           idx_q, idx_d;
   logic [6:0]                seg_q, seg_d, pat;
   logic [N_DIGITS-1:0]       an_q, an_d, an_oh;
   logic [3:0]                digit;
   logic                      higher_nz;

   function automatic logic [6:0] seg_lut(input logic [3:0] d);
      unique case (d)
         4'd0:    seg_lut = 7'h3F;
         4'd1:    seg_lut = 7'h06;
         4'd2:    seg_lut = 7'h5B;
         4'd3:    seg_lut = 7'h4F;
         4'd4:    seg_lut = 7'h66;
         4'd5:    seg_lut = 7'h6D;
         4'd6:    seg_lut = 7'h7D;
         4'd7:    seg_lut = 7'h07;
         4'd8:    seg_lut = 7'h7F;
         4'd9:    seg_lut = 7'h6F;
         default: seg_lut = 7'h00;
      endcase
   endfunction

   // Converter FSM next state: capture, add-3/shift for N_IN cycles, then latch.
   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      cnt_d     = cnt_q;
      ovf_nxt_d = ovf_nxt_q;
      ovf_d     = ovf_q;
      disp_d    = disp_q;
      done_d    = 1'b0;
      sr_adj    = sr_q;
      for (int j = 0; j < int'(N_DIGITS); j++) begin
         if (sr_q[N_IN + 4*j +: 4] >= 4'd5) begin
            sr_adj[N_IN + 4*j +: 4] = sr_q[N_IN + 4*j +: 4] + 4'd3;
         end
      end
      unique case (state_q)
         StIdle: begin
            if (load) begin
               sr_d      = {{(4*N_DIGITS){1'b0}}, bin_in};
               cnt_d     = CntW'(N_IN);
               ovf_nxt_d = (64'(bin_in) >= Limit);
               state_d   = StShift;
            end
         end
         StShift: begin
            // Carries out of the top nibble are dropped; overflow covers that case.
            sr_d  = {sr_adj[SrW-2:0], 1'b0};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CntW'(1)) begin
               state_d = StLatch;
            end
         end
         StLatch: begin
            disp_d  = sr_q[SrW-1 -: 4*N_DIGITS];
            ovf_d   = ovf_nxt_q;
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Scan prescaler/index and the segment pattern for the current digit slot.
   always_comb begin
      pre_d = pre_q + 1'b1;
      idx_d = idx_q;
      if (pre_q == PreW'(SCAN_DIV - 1)) begin
         pre_d = '0;
         idx_d = (idx_q == IdxW'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
      digit     = disp_q[4*int'(idx_q) +: 4];
      higher_nz = 1'b0;
      for (int k = 0; k < int'(N_DIGITS); k++) begin
         if ((k >= int'(idx_q)) && (disp_q[4*k +: 4] != 4'd0)) begin
            higher_nz = 1'b1;
         end
      end
      if (ovf_q) begin
         pat = 7'h40;
      end else if (blank_lz && (idx_q != '0) && !higher_nz) begin
         pat = 7'h00;
      end else begin
         pat = seg_lut(digit);
      end
      an_oh = N_DIGITS'(1) << idx_q;
      seg_d = SEG_ALOW ? ~pat : pat;
      an_d  = SEG_ALOW ? ~an_oh : an_oh;
   end

   // State registers with synchronous reset; reset outputs are the "off" level.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         sr_q      <= '0;
         cnt_q     <= '0;
         ovf_nxt_q <= 1'b0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
         disp_q    <= '0;
         pre_q     <= '0;
         idx_q     <= '0;
         seg_q     <= SEG_ALOW ? 7'h7F : 7'h00;
         an_q      <= SEG_ALOW ? '1 : '0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         cnt_q     <= cnt_d;
         ovf_nxt_q <= ovf_nxt_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
         disp_q    <= disp_d;
         pre_q     <= pre_d;
         idx_q     <= idx_d;
         seg_q     <= seg_d;
         an_q      <= an_d;
      end
   end

   assign busy     = (state_q != StIdle);
   assign done     = done_q;
   assign overflow = ovf_q;
   assign seg      = seg_q;
   assign an       = an_q;

endmodule
